symbol_modulator: RTL and testbench

SYMBOL_MODULATOR -- requirements
Module: symbol_modulator

---
 rtl/symbol_modulator.sv | 170 +++++++++++++++++
 tb/tb_symbol_modulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_modulator.sv
// symbol_modulator: byte-stream to 4-ary pulse-position line modulator.
//
// Bytes are queued in a small FIFO. When data is waiting, a burst starts at
// the next symbol boundary with PREAMBLE_SYMS alternating 11/00 symbols,
// followed by each byte as four dibits MSB first. Back-to-back bytes continue
// without a new preamble; an empty FIFO at a byte end returns to idle.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   tx_data/tx_valid  byte input, accepted when tx_ready is high
//   tx_ready          FIFO not full
//   clk_symbol        one-cycle strobe in the last cycle of every symbol
//   dout              modulated waveform for the current symbol and phase
//   sym_out           symbol currently on the line
//   busy              burst in progress (preamble or data)
module symbol_modulator #(
    parameter int SYM_LEN       = 128,
    parameter int PREAMBLE_SYMS = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       clk_symbol,
    output logic       dout,
    output logic [1:0] sym_out,
    output logic       busy
);
    localparam int PW = $clog2(SYM_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PREAMBLE_SYMS + 1);
    localparam int Q  = SYM_LEN / 4;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ph, ph_n;
    logic          boundary;
    logic [7:0]    sr, sr_n;
    logic [1:0]    didx, didx_n;
    logic [CW-1:0] pre_cnt, pre_n;
    logic [1:0]    sym_n;

    // FIFO: one extra pointer bit tells full from empty when indices match.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    logic [7:0]    head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_ready = !full;
    assign push     = tx_valid && !full;
    assign head     = mem[rd_ptr[AW-1:0]];

    assign boundary = (ph == PW'(SYM_LEN - 1));
    assign ph_n     = ph + 1'b1;
    assign busy     = (state != IDLE);

    function automatic logic wave(input logic [PW-1:0] p, input logic [1:0] s);
        case (s)
            2'b01:   wave = (int'(p) < Q);
            2'b10:   wave = (int'(p) < 2 * Q);
            2'b11:   wave = (int'(p) >= Q) && (int'(p) < 2 * Q);
            default: wave = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Next-state logic; every decision waits for the symbol boundary.
    always_comb begin
        state_n = state;
        sym_n   = sym_out;
        sr_n    = sr;
        didx_n  = didx;
        pre_n   = pre_cnt;
        pop     = 1'b0;
        if (boundary) begin
            case (state)
                IDLE: begin
                    sym_n = 2'b00;
                    if (!empty) begin
                        state_n = PREAMBLE;
                        sym_n   = 2'b11;
                        pre_n   = CW'(1);
                    end
                end
                PREAMBLE: begin
                    if (pre_cnt == CW'(PREAMBLE_SYMS)) begin
                        pre_n = '0;
                        if (!empty) begin
                            state_n = DATA;
                            pop     = 1'b1;
                            sr_n    = head;
                            sym_n   = head[7:6];
                            didx_n  = 2'd0;
                        end else begin
                            state_n = IDLE;
                            sym_n   = 2'b00;
                        end
                    end else begin
                        pre_n = pre_cnt + 1'b1;
                        // odd count means an 11 is on the line now
                        sym_n = pre_cnt[0] ? 2'b00 : 2'b11;
                    end
                end
                DATA: begin
                    if (didx == 2'd3) begin
                        didx_n = 2'd0;
                        if (!empty) begin
                            pop   = 1'b1;
                            sr_n  = head;
                            sym_n = head[7:6];
                        end else begin
                            state_n = IDLE;
                            sym_n   = 2'b00;
                        end
                    end else begin
                        // sr keeps the dibit on the line in [7:6]
                        didx_n = didx + 1'b1;
                        sr_n   = {sr[5:0], 2'b00};
                        sym_n  = sr[5:4];
                    end
                end
                default: begin
                    state_n = IDLE;
                    sym_n   = 2'b00;
                end
            endcase
        end
    end

    // dout is computed from next phase/symbol so it lines up with ph.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph         <= '0;
            clk_symbol <= 1'b0;
            dout       <= 1'b0;
            state      <= IDLE;
            sym_out    <= 2'b00;
            sr         <= '0;
            didx       <= '0;
            pre_cnt    <= '0;
        end else begin
            ph         <= ph_n;
            clk_symbol <= (ph == PW'(SYM_LEN - 2));
            dout       <= wave(ph_n, sym_n);
            state      <= state_n;
            sym_out    <= sym_n;
            sr         <= sr_n;
            didx       <= didx_n;
            pre_cnt    <= pre_n;
        end
    end
endmodule

// File: tb/tb_symbol_modulator.sv
// Bench for symbol_modulator: a 128-cycle instance and a 64-cycle instance.
// Stimulus queues the expected {busy, symbol} stream; per-instance monitors
// decode dout at 1/8 and 3/8 of each symbol and pop/compare against it.
module tb_symbol_modulator;
    logic       clk;
    logic       reset;
    logic       tx_valid_w [2];
    logic [7:0] tx_data_w  [2];
    logic       tx_ready_w [2];
    logic       clk_sym_w  [2];
    logic       dout_w     [2];
    logic [1:0] sym_w      [2];
    logic       busy_w     [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] q [$];

    symbol_modulator #(.SYM_LEN(128), .PREAMBLE_SYMS(4), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]),
        .tx_ready(tx_ready_w[0]), .clk_symbol(clk_sym_w[0]), .dout(dout_w[0]),
        .sym_out(sym_w[0]), .busy(busy_w[0]));

    symbol_modulator #(.SYM_LEN(64), .PREAMBLE_SYMS(4), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]),
        .tx_ready(tx_ready_w[1]), .clk_symbol(clk_sym_w[1]), .dout(dout_w[1]),
        .sym_out(sym_w[1]), .busy(busy_w[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic wave(input int p, input int sl, input logic [1:0] s);
        int qq = sl / 4;
        case (s)
            2'b01:   return p < qq;
            2'b10:   return p < 2 * qq;
            2'b11:   return (p >= qq) && (p < 2 * qq);
            default: return 1'b0;
        endcase
    endfunction

    // dout levels at 1/8 and 3/8 of the symbol -> symbol
    function automatic logic [1:0] decode(input logic [1:0] d);
        case (d)
            2'b10:   return 2'b01;
            2'b11:   return 2'b10;
            2'b01:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int SL = (g == 0) ? 128 : 64;
        int   ph;
        logic d0;
        logic active;

        always @(posedge clk or negedge reset) begin
            if (!reset) ph <= 0;
            else        ph <= (ph + 1) % SL;
        end

        always @(negedge clk) begin
            if (!reset) begin
                active <= 1'b0;
            end else begin
                chk($sformatf("clk_symbol%0d", g), clk_sym_w[g], ph == SL - 1);
                chk($sformatf("dout_wave%0d", g), dout_w[g], wave(ph, SL, sym_w[g]));
                if (ph == SL / 8) d0 <= dout_w[g];
                if (ph == 3 * SL / 8) begin
                    chk($sformatf("decode%0d", g), decode({d0, dout_w[g]}), sym_w[g]);
                    if (active || (busy_w[g] && q.size() != 0)) begin
                        if (q.size() == 0) begin
                            chk($sformatf("stream_underflow%0d", g), 1, 0);
                            active <= 1'b0;
                        end else begin
                            chk($sformatf("stream_busy%0d", g), busy_w[g], q[0][2]);
                            chk($sformatf("stream_sym%0d", g), sym_w[g], q[0][1:0]);
                            active <= (q.size() > 1);
                            void'(q.pop_front());
                        end
                    end else begin
                        chk($sformatf("idle_busy%0d", g), busy_w[g], 0);
                        chk($sformatf("idle_sym%0d", g), sym_w[g], 0);
                    end
                end
            end
        end
    end

    function automatic int cur_ph(input int g);
        return (g == 0) ? mon[0].ph : mon[1].ph;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ph(input int g, input int p);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (cur_ph(g) != p && n < 1000);
    endtask

    task automatic push(input int g, input logic [7:0] b);
        int n = 0;
        tx_data_w[g]  = b;
        tx_valid_w[g] = 1'b1;
        while (!tx_ready_w[g] && n < 3000) begin
            step(1);
            n++;
        end
        if (!tx_ready_w[g]) chk("push_timeout", 0, 1);
        step(1);
        tx_valid_w[g] = 1'b0;
    endtask

    task automatic exp_pre();
        for (int i = 0; i < 4; i++) q.push_back((i % 2 == 0) ? 3'b111 : 3'b100);
    endtask

    task automatic exp_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) q.push_back({1'b1, b[7-2*i -: 2]});
    endtask

    task automatic drain(input int g, input int sl);
        int n = 0;
        while (q.size() != 0 && n < 6000) begin
            step(1);
            n++;
        end
        chk("stream_drained", q.size(), 0);
        step(2 * sl);
    endtask

    initial begin
        logic [7:0] burst [5];
        burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h81;
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            tx_valid_w[g] = 1'b0;
            tx_data_w[g]  = 8'h00;
        end
        step(5);
        for (int g = 0; g < 2; g++) begin
            chk("rst_dout", dout_w[g], 0);
            chk("rst_clk_symbol", clk_sym_w[g], 0);
            chk("rst_sym", sym_w[g], 0);
            chk("rst_busy", busy_w[g], 0);
            chk("rst_tx_ready", tx_ready_w[g], 1);
        end
        reset = 1'b1;

        // idle line
        step(1000);

        // single byte
        wait_ph(0, 10);
        exp_pre();
        exp_byte(8'h1B);
        push(0, 8'h1B);
        drain(0, 128);

        // back-to-back burst overfilling the FIFO
        exp_pre();
        for (int i = 0; i < 5; i++) exp_byte(burst[i]);
        for (int i = 0; i < 4; i++) push(0, burst[i]);
        chk("tx_ready_full", tx_ready_w[0], 0);
        push(0, burst[4]);
        drain(0, 128);

        // byte arrives on the final-dibit boundary: one idle symbol, new preamble
        wait_ph(0, 10);
        exp_pre();
        exp_byte(8'h5A);
        q.push_back(3'b000);
        exp_pre();
        exp_byte(8'h96);
        push(0, 8'h5A);
        repeat (9) wait_ph(0, 127);
        push(0, 8'h96);
        drain(0, 128);

        // reset during the second dibit of 0xC3
        wait_ph(0, 10);
        exp_pre();
        q.push_back(3'b111);
        q.push_back(3'b100);
        push(0, 8'hC3);
        repeat (6) wait_ph(0, 127);
        wait_ph(0, 70);
        chk("pre_reset_stream", q.size(), 0);
        chk("pre_reset_busy", busy_w[0], 1);
        reset = 1'b0;
        q.delete();
        #1;
        chk("mid_reset_dout", dout_w[0], 0);
        chk("mid_reset_tx_ready", tx_ready_w[0], 1);
        chk("mid_reset_busy", busy_w[0], 0);
        chk("mid_reset_sym", sym_w[0], 0);
        step(3);
        reset = 1'b1;
        step(1000);

        // 64-cycle symbol instance
        wait_ph(1, 10);
        exp_pre();
        exp_byte(8'h6C);
        push(1, 8'h6C);
        drain(1, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
